nco_rx_monitor: RTL and testbench
=================================

// Module: nco_rx_monitor
// PURPOSE
//  Sink for the NCO sample stream (sin400k-style out_valid/fsin_o/fcos_o): takes signed sin/cos samples
//  and measures the sine period in samples from rising zero crossings. Captures per-period sin min/max,
//  compares the period against an expected value, and reports lock / sticky error to the control logic.
//  Sits directly downstream of the NCO, in the same clk domain.
// PARAMETERS
//  DW        14  sample width, two's complement
//  PER_W     16  period counter / result width
//  LOCK_CNT  4   consecutive in-tolerance periods required to assert locked_o (>=1)
// PORTS
//  clk           in   1      system clock (all logic rising-edge)
//  reset_n       in   1      synchronous, active-low reset
//  clken         in   1      clock enable; when 0 all state holds
//  out_valid     in   1      NCO sample valid
//  fsin_i        in   DW     NCO sine sample, signed
//  fcos_i        in   DW     NCO cosine sample, signed (only registered; reserved)
//  exp_period_i  in   PER_W  expected period in samples
//  tol_i         in   8      allowed |period - exp_period_i|
//  clear_i       in   1      clears err_o and ovf_o
//  period_o      out  PER_W  last measured period
//  period_vld_o  out  1      1-cycle pulse when period_o/sin_max_o/sin_min_o update
//  sin_max_o     out  DW     max sine value over last period
//  sin_min_o     out  DW     min sine value over last period
//  locked_o      out  1      high while in LOCK
//  err_o         out  1      sticky: out-of-tolerance period seen while in LOCK
//  ovf_o         out  1      sticky: period counter saturated
// BEHAVIOUR
//  Accept = reset_n & clken & out_valid; nothing changes on a non-accept cycle (except reset, clear_i).
//  Reset (reset_n=0 at posedge): state IDLE; all outputs 0; prev_ok=0, cnt=0, match=0.
//  Rising crossing on accepted sample s: prev_ok=1 and prev<0 and s>=0 (signed compare). prev<=s, prev_ok<=1.
//  Period counter cnt: crossing sample -> cnt<=1; otherwise cnt<=cnt+1, saturating at 2^PER_W-1;
//   saturating sets ovf_o and forces IDLE (match<=0, locked_o<=0).
//  Running min/max: crossing sample reloads both to s; else min<=min(min,s), max<=max(max,s).
//  States:
//   IDLE : cnt/min/max still run; first crossing -> ACQ. No period output.
//   ACQ  : on crossing: period_o<=cnt, sin_max_o/sin_min_o<=running max/min (excluding s),
//          period_vld_o=1 next cycle. In-tol (|cnt-exp|<=tol_i, unsigned PER_W+1 diff): match+1;
//          match reaching LOCK_CNT -> LOCK, locked_o<=1. Out-of-tol: match<=0, stay ACQ.
//   LOCK : same measurement on crossing; out-of-tol -> err_o<=1, locked_o<=0, match<=0, ACQ.
//  Latency: period_o, sin_*_o, period_vld_o, locked_o, err_o register on the crossing sample's clock edge.
//  clear_i: clears err_o/ovf_o that cycle; if same cycle sets err_o/ovf_o, set wins.
//  reset_n low mid-period: measurement discarded; restart in IDLE, prev_ok=0 (1st sample never a crossing).
//  s==0 after negative prev is a crossing; prev==0 -> s>0 is not (prev not <0).
//  exp_period_i/tol_i sampled only at crossings; changing them mid-run affects next comparison only.
// TESTING
//  1 Reset: hold reset_n=0 10 cycles w/ valid samples -> all outputs 0, period_vld_o never pulses.
//  2 NCO clk period 6400ps, phi_inc=32'h00A7C5AC, exp=390, tol=1, clken=1 -> periods 390/391,
//    first period_vld_o at 2nd crossing, locked_o after 4th in-tol period, sin_max_o>=8180, sin_min_o<=-8180.
//  3 Locked, then phi_inc step to 32'h014F8B58 (~195 samples) -> next period out of tol: err_o=1,
//    locked_o=0; clear_i pulse -> err_o=0; re-lock with exp=195.
//  4 Gaps: clken/out_valid low every 3rd cycle on a 390-sample synthetic sine -> period_o still 390.
//  5 PER_W=8, constant +100 input -> cnt saturates at 255, ovf_o=1, state IDLE, locked_o=0.
//  6 Edge crossings: sequence -3,0,5,-2,-1,4 -> crossings at 0 and 4 only; period_o=4.

Source files
------------

// File: rtl/nco_rx_monitor.sv
// -----------------------------------------------------------------------------
// nco_rx_monitor
//
// Sink for the NCO sample stream. Measures the sine period in samples between
// rising zero crossings. Also captures the sine min/max over each period,
// compares the period against an expected value with a tolerance, and reports
// lock and sticky error/overflow flags.
//
// Handshake: a sample is taken on a rising clk edge when reset_n, clken and
// out_valid are all high (an "accept"). There is no back-pressure. The NCO
// presents a new sample whenever out_valid is high. Nothing but clear_i and
// reset moves on a non-accept edge.
//
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   clken            clock enable (low: all state holds)
//   out_valid        sample valid from the NCO
//   fsin_i, fcos_i   signed sine / cosine samples (cosine only registered)
//   exp_period_i     expected period in samples, sampled at crossings
//   tol_i            allowed |period - exp_period_i|, sampled at crossings
//   clear_i          clears err_o / ovf_o (a same-cycle set wins)
//   period_o         last measured period
//   period_vld_o     one-cycle pulse when period_o / sin_*_o update
//   sin_max_o/min_o  sine max/min over the last period
//   locked_o         high while in LOCK
//   err_o            sticky: out-of-tolerance period while locked
//   ovf_o            sticky: period counter saturated
//   dbg_state_o      FSM state (0 IDLE, 1 ACQ, 2 LOCK)
//   dbg_cos_o        registered cosine sample, reserved for quadrature checks
// -----------------------------------------------------------------------------
module nco_rx_monitor #(
  parameter int DW       = 14,
  parameter int PER_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    out_valid,
  input  logic signed [DW-1:0]    fsin_i,
  input  logic signed [DW-1:0]    fcos_i,
  input  logic        [PER_W-1:0] exp_period_i,
  input  logic        [7:0]       tol_i,
  input  logic                    clear_i,
  output logic        [PER_W-1:0] period_o,
  output logic                    period_vld_o,
  output logic signed [DW-1:0]    sin_max_o,
  output logic signed [DW-1:0]    sin_min_o,
  output logic                    locked_o,
  output logic                    err_o,
  output logic                    ovf_o,
  output logic        [1:0]       dbg_state_o,
  output logic signed [DW-1:0]    dbg_cos_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [PER_W-1:0] CNT_MAX  = {PER_W{1'b1}};
  // One below saturation: incrementing from here (or holding at max) saturates.
  localparam logic [PER_W-1:0] CNT_NEAR = {{(PER_W-1){1'b1}}, 1'b0};

  state_t                   state_q;
  logic signed [DW-1:0]     prev_q;
  logic                     prev_ok_q;
  logic        [PER_W-1:0]  cnt_q, cnt_d;
  logic signed [DW-1:0]     run_min_q, run_min_d;
  logic signed [DW-1:0]     run_max_q, run_max_d;
  logic        [MW-1:0]     match_q;
  logic        [PER_W-1:0]  period_q;
  logic                     period_vld_q;
  logic signed [DW-1:0]     sin_max_q, sin_min_q;
  logic                     locked_q, err_q, ovf_q;
  logic signed [DW-1:0]     cos_q;

  logic                     accept;
  logic                     crossing;
  logic                     sat;
  logic        [PER_W:0]    cnt_ext, exp_ext, abs_diff, tol_ext;
  logic                     in_tol;
  logic        [MW-1:0]     match_inc;

  assign accept   = clken & out_valid;
  // prev < 0 and s >= 0 reduces to the two sign bits.
  assign crossing = prev_ok_q & prev_q[DW-1] & ~fsin_i[DW-1];
  assign sat      = ~crossing & (cnt_q >= CNT_NEAR);

  // Distance is taken in PER_W+1 bits so it can never wrap.
  always_comb begin
    cnt_ext   = {1'b0, cnt_q};
    exp_ext   = {1'b0, exp_period_i};
    abs_diff  = (cnt_ext >= exp_ext) ? (cnt_ext - exp_ext) : (exp_ext - cnt_ext);
    tol_ext   = (PER_W+1)'(tol_i);
    in_tol    = (abs_diff <= tol_ext);
    match_inc = match_q + MW'(1);
  end

  always_comb begin
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    if (crossing) begin
      cnt_d     = PER_W'(1);
      run_min_d = fsin_i;
      run_max_d = fsin_i;
    end else begin
      cnt_d     = sat ? CNT_MAX : (cnt_q + PER_W'(1));
      run_min_d = (fsin_i < run_min_q) ? fsin_i : run_min_q;
      run_max_d = (fsin_i > run_max_q) ? fsin_i : run_max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      cnt_q        <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      match_q      <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      sin_max_q    <= '0;
      sin_min_q    <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      cos_q        <= '0;
    end else begin
      period_vld_q <= 1'b0;
      // Clear first so a set further down in the same cycle takes priority.
      if (clear_i) begin
        err_q <= 1'b0;
        ovf_q <= 1'b0;
      end
      if (accept) begin
        prev_q    <= fsin_i;
        prev_ok_q <= 1'b1;
        cos_q     <= fcos_i;
        cnt_q     <= cnt_d;
        run_min_q <= run_min_d;
        run_max_q <= run_max_d;
        if (crossing) begin
          if (state_q != ST_IDLE) begin
            // Running extremes still exclude the crossing sample here.
            period_q     <= cnt_q;
            sin_max_q    <= run_max_q;
            sin_min_q    <= run_min_q;
            period_vld_q <= 1'b1;
          end
          case (state_q)
            ST_IDLE: state_q <= ST_ACQ;
            ST_ACQ: begin
              if (in_tol) begin
                match_q <= match_inc;
                if (match_inc >= MW'(LOCK_CNT)) begin
                  state_q  <= ST_LOCK;
                  locked_q <= 1'b1;
                end
              end else begin
                match_q <= '0;
              end
            end
            ST_LOCK: begin
              if (!in_tol) begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                match_q  <= '0;
                state_q  <= ST_ACQ;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end else if (sat) begin
          // No crossing for 2^PER_W-1 samples: the measurement is meaningless.
          ovf_q    <= 1'b1;
          state_q  <= ST_IDLE;
          match_q  <= '0;
          locked_q <= 1'b0;
        end
      end
    end
  end

  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;
  assign sin_max_o    = sin_max_q;
  assign sin_min_o    = sin_min_q;
  assign locked_o     = locked_q;
  assign err_o        = err_q;
  assign ovf_o        = ovf_q;
  assign dbg_state_o  = state_q;
  assign dbg_cos_o    = cos_q;

endmodule

// File: tb/tb_nco_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_nco_rx_monitor
//
// Bench for nco_rx_monitor. A 16-bit-period instance covers reset, NCO lock,
// frequency step / error / clear, gapped input and zero-crossing edge cases.
// An 8-bit-period instance covers counter saturation. A reference model of the
// crossing/period/min/max behaviour pushes the expected {period, max, min} into
// a queue. The queue is popped whenever period_vld_o pulses.
// -----------------------------------------------------------------------------
module tb_nco_rx_monitor;

  localparam int DW = 14;
  localparam int PW = 16;
  localparam int IW = PW + 2 * DW;
  localparam real PI2 = 6.283185307179586;

  logic clk;
  logic reset_n;

  // 16-bit period instance
  logic                 clken, out_valid, clear_i;
  logic signed [DW-1:0] fsin_i, fcos_i;
  logic [PW-1:0]        exp_period_i;
  logic [7:0]           tol_i;
  logic [PW-1:0]        period_o;
  logic                 period_vld_o, locked_o, err_o, ovf_o;
  logic signed [DW-1:0] sin_max_o, sin_min_o, dbg_cos_o;
  logic [1:0]           dbg_state_o;

  // 8-bit period instance
  logic                 clken8, out_valid8, clear8;
  logic signed [DW-1:0] fsin8;
  logic [7:0]           period8;
  logic                 vld8, locked8, err8, ovf8;
  logic signed [DW-1:0] max8, min8, cos8;
  logic [1:0]           state8;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] exp_q[$];

  // Reference model state
  logic signed [DW-1:0] m_prev, m_min, m_max;
  logic                 m_prev_ok, m_armed;
  logic [PW-1:0]        m_cnt;
  int                   n_cross;
  logic [31:0]          ph;

  nco_rx_monitor #(.DW(DW), .PER_W(PW), .LOCK_CNT(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .out_valid(out_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .exp_period_i(exp_period_i),
    .tol_i(tol_i), .clear_i(clear_i), .period_o(period_o),
    .period_vld_o(period_vld_o), .sin_max_o(sin_max_o), .sin_min_o(sin_min_o),
    .locked_o(locked_o), .err_o(err_o), .ovf_o(ovf_o),
    .dbg_state_o(dbg_state_o), .dbg_cos_o(dbg_cos_o)
  );

  nco_rx_monitor #(.DW(DW), .PER_W(8), .LOCK_CNT(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .clken(clken8), .out_valid(out_valid8),
    .fsin_i(fsin8), .fcos_i(fsin8), .exp_period_i(8'd100),
    .tol_i(8'd0), .clear_i(clear8), .period_o(period8),
    .period_vld_o(vld8), .sin_max_o(max8), .sin_min_o(min8),
    .locked_o(locked8), .err_o(err8), .ovf_o(ovf8),
    .dbg_state_o(state8), .dbg_cos_o(cos8)
  );

  // ---------------- clock / reset defaults ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [IW-1:0] item;
    if (period_vld_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: period_vld_o with period_o=%0d, nothing expected", period_o);
      end else begin
        item = exp_q.pop_front();
        if ({period_o, sin_max_o, sin_min_o} !== item) begin
          failures++;
          $display("FAIL sb_period: got period=%0d max=%0d min=%0d, expected period=%0d max=%0d min=%0d",
                   period_o, sin_max_o, sin_min_o, item[IW-1 -: PW],
                   $signed(item[2*DW-1 -: DW]), $signed(item[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    m_prev = '0; m_min = '0; m_max = '0;
    m_prev_ok = 1'b0; m_armed = 1'b0; m_cnt = '0; n_cross = 0;
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, return just after the next posedge.
  task automatic drive(input logic signed [DW-1:0] s, input logic v, input logic ce);
    @(negedge clk);
    fsin_i = s; fcos_i = ~s; out_valid = v; clken = ce;
    if (v && ce && reset_n) begin
      if (m_prev_ok && m_prev < 0 && s >= 0) begin
        if (m_armed) exp_q.push_back({m_cnt, m_max, m_min});
        m_armed = 1'b1; m_cnt = 1; m_max = s; m_min = s;
        n_cross++;
      end else begin
        if (m_cnt >= 16'hFFFE) begin m_cnt = 16'hFFFF; m_armed = 1'b0; end
        else m_cnt = m_cnt + 1'b1;
        if (s < m_min) m_min = s;
        if (s > m_max) m_max = s;
      end
      m_prev = s; m_prev_ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive8(input logic signed [DW-1:0] s, input logic v);
    @(negedge clk);
    fsin8 = s; out_valid8 = v; clken8 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic nco_step(input logic [31:0] inc);
    int v;
    v = $rtoi(8191.0 * $sin(PI2 * real'(ph) / 4294967296.0));
    drive(DW'(v), 1'b1, 1'b1);
    ph = ph + inc;
  endtask

  task automatic do_reset();
    drive(fsin_i, 1'b0, 1'b1);
    drive(fsin_i, 1'b0, 1'b1);
    reset_n = 1'b0;
    repeat (3) drive(DW'($urandom_range(0, 16383)), 1'b1, 1'b1);
    reset_n = 1'b1; out_valid = 1'b0; clear_i = 1'b0;
    out_valid8 = 1'b0; clear8 = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive('0, 1'b0, 1'b1);
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(DW'($urandom_range(0, 16383)), 1'b1, 1'b1);
      checks++;
      if ({period_o, period_vld_o, sin_max_o, sin_min_o, locked_o, err_o, ovf_o, dbg_state_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: cycle %0d period=%0d vld=%0b max=%0d min=%0d lock=%0b err=%0b ovf=%0b st=%0d, expected all 0",
                 i, period_o, period_vld_o, sin_max_o, sin_min_o, locked_o, err_o, ovf_o, dbg_state_o);
      end
    end
    reset_n = 1'b1; out_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_nco_lock();
    do_reset();
    exp_period_i = 16'd390; tol_i = 8'd1; ph = '0;
    for (int i = 0; i < 4000 && n_cross < 5; i++) begin
      nco_step(32'h00A7C5AC);
      checks++;
      if (locked_o !== (n_cross >= 5)) begin
        failures++;
        $display("FAIL nco_locked: locked_o=%0b after crossing %0d, expected %0b", locked_o, n_cross, n_cross >= 5);
      end
    end
    checks++;
    if (n_cross != 5) begin
      failures++;
      $display("FAIL nco_timeout: reached %0d crossings, expected 5", n_cross);
    end
    checks++;
    if (period_o < 16'd390 || period_o > 16'd391) begin
      failures++;
      $display("FAIL nco_period: period_o=%0d, expected 390 or 391", period_o);
    end
    checks++;
    if (sin_max_o < 14'sd8180 || sin_min_o > -14'sd8180) begin
      failures++;
      $display("FAIL nco_amplitude: max=%0d min=%0d, expected max>=8180 min<=-8180", sin_max_o, sin_min_o);
    end
  endtask

  task automatic test_freq_step();
    // Continues from lock; the step lands right after a crossing.
    for (int i = 0; i < 1000 && n_cross < 6; i++) nco_step(32'h014F8B58);
    checks++;
    if (n_cross != 6 || err_o !== 1'b1 || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL step_err: crossings=%0d err_o=%0b locked_o=%0b, expected 6/1/0", n_cross, err_o, locked_o);
    end
    exp_period_i = 16'd195;
    clear_i = 1'b1;
    drive(fsin_i, 1'b0, 1'b1);
    clear_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL step_clear: err_o=%0b after clear_i, expected 0", err_o);
    end
    for (int i = 0; i < 2000 && n_cross < 10; i++) begin
      nco_step(32'h014F8B58);
      checks++;
      if (locked_o !== (n_cross >= 10) || err_o !== 1'b0) begin
        failures++;
        $display("FAIL step_relock: locked_o=%0b err_o=%0b at crossing %0d, expected %0b/0",
                 locked_o, err_o, n_cross, n_cross >= 10);
      end
    end
    checks++;
    if (n_cross != 10) begin
      failures++;
      $display("FAIL step_timeout: reached %0d crossings, expected 10", n_cross);
    end
  endtask

  task automatic test_gaps();
    int k, v;
    logic signed [DW-1:0] s;
    do_reset();
    exp_period_i = 16'd390; tol_i = 8'd0; k = 0;
    for (int c = 0; c < 4000 && n_cross < 6; c++) begin
      v = $rtoi(8000.0 * $sin(PI2 * real'(k % 390) / 390.0));
      s = DW'(v);
      if (c % 3 == 2) begin
        // Alternate which of out_valid / clken is dropped.
        drive(s, (c % 6 == 2) ? 1'b0 : 1'b1, (c % 6 == 5) ? 1'b0 : 1'b1);
      end else begin
        drive(s, 1'b1, 1'b1);
        k++;
      end
    end
    checks++;
    if (n_cross != 6 || period_o !== 16'd390 || locked_o !== 1'b1) begin
      failures++;
      $display("FAIL gaps_period: crossings=%0d period_o=%0d locked_o=%0b, expected 6/390/1",
               n_cross, period_o, locked_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 254; i++) begin
      drive8(14'sd100, 1'b1);
      checks++;
      if (vld8 !== 1'b0 || ovf8 !== 1'b0) begin
        failures++;
        $display("FAIL ovf_early: sample %0d vld=%0b ovf=%0b, expected 0/0", i + 1, vld8, ovf8);
      end
    end
    drive8(14'sd100, 1'b1);
    checks++;
    if (ovf8 !== 1'b1 || state8 !== 2'd0 || locked8 !== 1'b0 || vld8 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sat: ovf=%0b state=%0d locked=%0b vld=%0b, expected 1/0/0/0", ovf8, state8, locked8, vld8);
    end
    clear8 = 1'b1;
    drive8(14'sd100, 1'b1);
    checks++;
    if (ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%0b with clear and saturation together, expected 1", ovf8);
    end
    drive8(14'sd100, 1'b0);
    clear8 = 1'b0;
    checks++;
    if (ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%0b after clear, expected 0", ovf8);
    end
  endtask

  task automatic test_edge_crossings();
    logic signed [DW-1:0] seq [8];
    seq = '{-14'sd3, 14'sd0, 14'sd5, -14'sd2, -14'sd1, 14'sd4, 14'sd0, 14'sd3};
    do_reset();
    exp_period_i = 16'd4; tol_i = 8'd0;
    for (int i = 0; i < 8; i++) begin
      drive(seq[i], 1'b1, 1'b1);
      checks++;
      if (period_vld_o !== (i == 5)) begin
        failures++;
        $display("FAIL edge_vld: period_vld_o=%0b after sample %0d, expected %0b", period_vld_o, i, i == 5);
      end
      if (i == 5) begin
        checks++;
        if (period_o !== 16'd4 || sin_max_o !== 14'sd5 || sin_min_o !== -14'sd2) begin
          failures++;
          $display("FAIL edge_period: period=%0d max=%0d min=%0d, expected 4/5/-2", period_o, sin_max_o, sin_min_o);
        end
      end
    end
    drive(fsin_i, 1'b0, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected results never produced, expected 0", exp_q.size());
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset_n = 1'b0; clken = 1'b0; out_valid = 1'b0; clear_i = 1'b0;
    fsin_i = '0; fcos_i = '0; exp_period_i = '0; tol_i = '0;
    clken8 = 1'b0; out_valid8 = 1'b0; clear8 = 1'b0; fsin8 = '0;
    ph = '0;
    model_clear();
    test_reset();
    test_nco_lock();
    test_freq_step();
    test_gaps();
    test_overflow();
    test_edge_crossings();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
